// File: rtl/mem_stage_access_unit_pkg.sv
// Shared types for the MEM-stage access unit: access sizes, FSM states, fault check.
package mem_stage_access_unit_pkg;

  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  // Misalignment, reserved size, or a load and a store requested together.
  function automatic logic f_is_fault(input logic rd, input logic wr,
                                      input mem_size_e size, input logic [1:0] lo);
    return (rd & wr) | (size == SZ_RSVD) | ((size == SZ_HALF) & lo[0]) |
           ((size == SZ_WORD) & (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data path: picks the addressed byte/half lane out of the bus word and extends it.
module mem_load_align
  import mem_stage_access_unit_pkg::*;
(
  input  logic [DMEM_DATA_W-1:0] i_rdata,
  input  logic [1:0]             i_lane,
  input  mem_size_e              i_size,
  input  logic                   i_unsigned,
  output logic [DMEM_DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage controller: turns an EX/MEM load/store into a req/ack data-memory transaction,
// stalls the pipeline while it is outstanding and flags bad or timed-out accesses.
module mem_stage_access_unit
  import mem_stage_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic [1:0]             i_mem_size,
  input  logic                   i_mem_unsigned,
  input  logic [31:0]            i_alu_result,
  input  logic [31:0]            i_write_data,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  output logic [ADDR_WIDTH-1:0]  o_dmem_addr,
  output logic [3:0]             o_dmem_be,
  output logic [DMEM_DATA_W-1:0] o_dmem_wdata,
  input  logic [DMEM_DATA_W-1:0] i_dmem_rdata,
  input  logic                   i_dmem_ack,
  output logic [DMEM_DATA_W-1:0] o_read_data_out,
  output logic                   o_stall_out,
  output logic                   o_mem_fault_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 r_state, w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [3:0]             r_be;
  logic [DMEM_DATA_W-1:0] r_wdata;
  logic                   r_we;
  logic [1:0]             r_lane;
  mem_size_e              r_size;
  logic                   r_unsigned;
  logic [CNT_W-1:0]       r_cnt;
  logic [DMEM_DATA_W-1:0] r_rdata_out;

  mem_size_e              w_size;
  logic                   w_access, w_fault, w_start, w_bad_idle, w_timeout_hit;
  logic [3:0]             w_be;
  logic [DMEM_DATA_W-1:0] w_wdata, w_load;
  logic [31:0]            w_addr_word;

  assign w_size        = mem_size_e'(i_mem_size);
  assign w_access      = i_mem_read | i_mem_write;
  assign w_fault       = f_is_fault(i_mem_read, i_mem_write, w_size, i_alu_result[1:0]);
  assign w_addr_word   = {i_alu_result[31:2], 2'b00};
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  // Store lanes: narrow data is replicated so every enabled lane sees it.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_write_data;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << i_alu_result[1:0];
        w_wdata = {4{i_write_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = i_alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align u_load_align (
    .i_rdata    (i_dmem_rdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    o_dmem_req      = 1'b0;
    o_stall_out     = 1'b0;
    o_mem_fault_out = 1'b0;
    w_start         = 1'b0;
    w_bad_idle      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access && w_fault) begin
          o_mem_fault_out = 1'b1;
          w_bad_idle      = 1'b1;
        end else if (w_access) begin
          o_stall_out = 1'b1;
          w_start     = 1'b1;
          w_next      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        o_dmem_req  = 1'b1;
        o_stall_out = 1'b1;
        if (i_dmem_ack) begin
          w_next = ST_DONE;
        end else if (w_timeout_hit) begin
          o_mem_fault_out = 1'b1;
          w_next          = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_lane      <= '0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_cnt       <= '0;
      r_rdata_out <= '0;
    end else begin
      if (w_start) begin
        r_addr     <= w_addr_word[ADDR_WIDTH-1:0];
        r_be       <= w_be;
        r_wdata    <= w_wdata;
        r_we       <= i_mem_write;
        r_lane     <= i_alu_result[1:0];
        r_size     <= w_size;
        r_unsigned <= i_mem_unsigned;
        r_cnt      <= '0;
      end
      if (w_bad_idle) r_rdata_out <= '0;
      if (r_state == ST_ACCESS) begin
        if (i_dmem_ack)         r_rdata_out <= r_we ? '0 : w_load;
        else if (w_timeout_hit) r_rdata_out <= '0;
        else                    r_cnt       <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_dmem_we       = r_we;
  assign o_dmem_addr     = r_addr;
  assign o_dmem_be       = r_be;
  assign o_dmem_wdata    = r_wdata;
  assign o_read_data_out = r_rdata_out;

endmodule
